md_ctrl: RTL and testbench

- Sequencing and hazard controller for the pipeline's multiply/divide unit.
- Takes the E-stage MD operation, generates the unit's start/write strobes and tracks latency with its own counter.
- Owns the authoritative busy flag and produces the D-stage stall for MD-class instructions.
- Suppresses issue when the E-stage instruction is killed by an exception.

---
 rtl/md_pkg.sv | 35 +++
 rtl/md_lat_counter.sv | 44 ++++
 rtl/md_ctrl.sv | 169 ++++++++++++++++
 tb/tb_md_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencing controller:
// op codes, FSM state encoding, default latencies and a latency lookup.
package md_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;
    localparam logic [2:0] MD_RSVD  = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MD_MULT_LAT_DEF = 32'd5;
    localparam int unsigned MD_DIV_LAT_DEF  = 32'd10;
    localparam int unsigned MD_CNT_W_DEF    = 32'd4;

    // Start-to-commit latency of a long-running op; divides use the divide
    // latency, everything else the multiply latency.
    function automatic int unsigned md_lat_of(input logic [2:0] op,
                                              input int unsigned mult_lat,
                                              input int unsigned div_lat);
        if ((op == MD_DIV) || (op == MD_DIVU)) begin
            return div_lat;
        end else begin
            return mult_lat;
        end
    endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Down-counter tracking the remaining latency of the in-flight MD op.
// load has priority over dec; the counter holds at zero.
module md_lat_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: load a fresh latency, otherwise step down towards zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/md_ctrl.sv
// Sequencing and hazard controller for the multiply/divide unit.
// Issues start/write strobes from the E stage, counts operation latency,
// owns the busy flag and produces the D-stage stall for MD-class instructions.
// Optional: define MD_STALL_CNT_EN to add a saturating 32-bit stall_cnt output.
module md_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MULT_LAT = MD_MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = MD_DIV_LAT_DEF,
    parameter int unsigned CNT_W    = MD_CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e_valid,
    input  logic [2:0] e_op,
    input  logic       e_err,
    input  logic       d_md_use,
    output logic       md_start,
    output logic [2:0] md_op,
    output logic       md_wr_hi,
    output logic       md_wr_lo,
    output logic       md_commit,
    output logic       busy,
    output logic       stall_d,
    output logic       proto_err
`ifdef MD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    md_state_e        state_d, state_q;
    logic             busy_d, busy_q;
    logic [2:0]       md_op_d, md_op_q;
    logic             commit_d, commit_q;
    logic             perr_d, perr_q;

    logic             issue_s;
    logic             md_class_s;
    logic             live_s;
    int unsigned      lat_s;
    logic [CNT_W-1:0] load_val_s;
    logic             cnt_load_s;
    logic             cnt_dec_s;
    logic [CNT_W-1:0] cnt_s;
    logic             cnt_zero_s;

    md_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load_s),
        .load_val (load_val_s),
        .dec      (cnt_dec_s),
        .cnt      (cnt_s),
        .zero     (cnt_zero_s)
    );

    // Decode the E-stage op: live instruction, long-running issue, any MD op.
    always_comb begin
        live_s     = e_valid && !e_err;
        issue_s    = live_s && (e_op >= MD_MULT) && (e_op <= MD_DIVU);
        md_class_s = (e_op >= MD_MULT) && (e_op <= MD_MTLO);
        lat_s      = md_lat_of(e_op, MULT_LAT, DIV_LAT);
        load_val_s = CNT_W'(lat_s - 32'd1);
    end

    // Next-state logic; commit is raised one cycle early so the registered
    // pulse lands in the cycle the counter reads zero.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        md_op_d    = md_op_q;
        commit_d   = 1'b0;
        perr_d     = perr_q;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_s) begin
                    state_d    = RUN;
                    busy_d     = 1'b1;
                    md_op_d    = e_op;
                    cnt_load_s = 1'b1;
                    commit_d   = (load_val_s == '0);
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Any MD op reaching E now means the D-stage stall was bypassed.
                if (e_valid && md_class_s) begin
                    perr_d = 1'b1;
                end else begin
                    perr_d = perr_q;
                end
                if (cnt_zero_s) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_dec_s = 1'b1;
                    commit_d  = (cnt_s == CNT_ONE);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            md_op_q  <= MD_NONE;
            commit_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            md_op_q  <= md_op_d;
            commit_q <= commit_d;
            perr_q   <= perr_d;
        end
    end

    // Combinational strobes, all forced low while reset is asserted.
    always_comb begin
        md_start = !reset && (state_q == IDLE) && issue_s;
        md_wr_hi = !reset && (state_q == IDLE) && live_s && (e_op == MD_MTHI);
        md_wr_lo = !reset && (state_q == IDLE) && live_s && (e_op == MD_MTLO);
        stall_d  = !reset && d_md_use && (busy_q || issue_s);
    end

    assign md_op     = md_op_q;
    assign md_commit = commit_q;
    assign busy      = busy_q;
    assign proto_err = perr_q;

`ifdef MD_STALL_CNT_EN
    logic [31:0] stall_cnt_d, stall_cnt_q;

    // Saturating count of D-stage stall cycles.
    always_comb begin
        if (stall_d && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: each stimulus cycle pushes the hand-derived
// expected output vector; a negedge monitor pops and compares it.
// Vector layout: {start, wr_hi, wr_lo, commit, busy, stall_d, proto_err, md_op[2:0]}
module tb_md_ctrl;

    logic       clk;
    logic       reset;
    logic       e_valid;
    logic [2:0] e_op;
    logic       e_err;
    logic       d_md_use;
    logic       md_start;
    logic [2:0] md_op;
    logic       md_wr_hi;
    logic       md_wr_lo;
    logic       md_commit;
    logic       busy;
    logic       stall_d;
    logic       proto_err;
`ifdef MD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    md_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .e_valid   (e_valid),
        .e_op      (e_op),
        .e_err     (e_err),
        .d_md_use  (d_md_use),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_wr_hi  (md_wr_hi),
        .md_wr_lo  (md_wr_lo),
        .md_commit (md_commit),
        .busy      (busy),
        .stall_d   (stall_d),
        .proto_err (proto_err)
`ifdef MD_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct {
        int         cyc;
        logic [9:0] v;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    logic [9:0] act;
    int         cyc;
    int         tests_run;
    int         tests_failed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare the expectation scheduled for this cycle, and flag any
    // strobe that appears when nothing was expected.
    always @(negedge clk) begin
        act = {md_start, md_wr_hi, md_wr_lo, md_commit, busy, stall_d, proto_err, md_op};
        if ((exp_q.size() > 0) && (exp_q[0].cyc == cyc)) begin
            cur = exp_q.pop_front();
            tests_run = tests_run + 1;
            if (act !== cur.v) begin
                tests_failed = tests_failed + 1;
                $display("FAIL %s cyc=%0d actual=%b required=%b", cur.name, cyc, act, cur.v);
            end
        end else if (md_start || md_wr_hi || md_wr_lo || md_commit) begin
            tests_run = tests_run + 1;
            tests_failed = tests_failed + 1;
            $display("FAIL unexpected_strobe cyc=%0d actual=%b required=no strobe", cyc, act);
        end
    end

    function automatic logic [9:0] ev(input bit st, input bit hi, input bit lo, input bit cm,
                                      input bit bz, input bit sl, input bit pe,
                                      input logic [2:0] op);
        return {st, hi, lo, cm, bz, sl, pe, op};
    endfunction

    task automatic step(input logic rst, input logic v, input logic [2:0] op, input logic err,
                        input logic duse, input logic [9:0] exp_v, input string name);
        reset    = rst;
        e_valid  = v;
        e_op     = op;
        e_err    = err;
        d_md_use = duse;
        exp_q.push_back('{cyc: cyc, v: exp_v, name: name});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc          = 0;
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        e_valid      = 1'b0;
        e_op         = 3'd0;
        e_err        = 1'b0;
        d_md_use     = 1'b0;
        @(posedge clk);
        #1;

        // Reset: strobes suppressed even with a live mult and d_md_use.
        step(1'b1, 1'b1, 3'd1, 1'b0, 1'b1, ev(0,0,0,0,0,0,0,3'd0), "reset_gate");
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,3'd0), "reset_state");

        // mult: start at T, busy T+1..T+5, commit T+5, idle T+6.
        step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, ev(1,0,0,0,0,0,0,3'd0), "mult_start");
        for (int k = 1; k <= 5; k++)
            step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, ev(0,0,0,(k == 5),1,0,0,3'd1), "mult_run");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,3'd1), "mult_done");

        // divu with d_md_use held: stall T..T+10, released T+11.
        step(1'b0, 1'b1, 3'd4, 1'b0, 1'b1, ev(1,0,0,0,0,1,0,3'd1), "divu_start");
        for (int k = 1; k <= 10; k++)
            step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, ev(0,0,0,(k == 10),1,1,0,3'd4), "divu_run");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, ev(0,0,0,0,0,0,0,3'd4), "divu_release");

        // Killed issue, then mthi and mtlo write strobes.
        step(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,3'd4), "killed_issue");
        step(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, ev(0,1,0,0,0,0,0,3'd4), "mthi_strobe");
        step(1'b0, 1'b1, 3'd6, 1'b0, 1'b0, ev(0,0,1,0,0,0,0,3'd4), "mtlo_strobe");
        step(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,3'd4), "reserved_op");
        step(1'b0, 1'b1, 3'd5, 1'b1, 1'b0, ev(0,0,0,0,0,0,0,3'd4), "killed_mthi");

        // div with e_err pulse at T+3: commit still at T+10.
        step(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, ev(1,0,0,0,0,0,0,3'd4), "div_start");
        for (int k = 1; k <= 10; k++)
            step(1'b0, 1'b0, 3'd0, (k == 3), 1'b0, ev(0,0,0,(k == 10),1,0,0,3'd3), "div_err_run");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,3'd3), "div_done");

        // mult then reset at T+2: no commit from it; re-issue at T+3.
        step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, ev(1,0,0,0,0,0,0,3'd3), "abort_start");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, ev(0,0,0,0,1,0,0,3'd1), "abort_run");
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, ev(0,0,0,0,1,0,0,3'd1), "abort_reset");
        step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, ev(1,0,0,0,0,0,0,3'd0), "reissue_start");
        for (int k = 1; k <= 5; k++)
            step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, ev(0,0,0,(k == 5),1,0,0,3'd1), "reissue_run");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,3'd1), "reissue_done");

        // Protocol violation: mtlo forced into E at T+2 while busy.
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,3'd1), "pre_proto_reset");
        step(1'b0, 1'b1, 3'd2, 1'b0, 1'b1, ev(1,0,0,0,0,1,0,3'd0), "multu_start");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, ev(0,0,0,0,1,1,0,3'd2), "multu_run");
        step(1'b0, 1'b1, 3'd6, 1'b0, 1'b1, ev(0,0,0,0,1,1,0,3'd2), "forced_mtlo");
        for (int k = 3; k <= 5; k++)
            step(1'b0, (k == 4), 3'd1, 1'b0, 1'b1, ev(0,0,0,(k == 5),1,1,1,3'd2), "proto_sticky");
`ifdef MD_STALL_CNT_EN
        tests_run = tests_run + 1;
        if (stall_cnt !== 32'd6) begin
            tests_failed = tests_failed + 1;
            $display("FAIL stall_cnt actual=%0d required=6", stall_cnt);
        end
`endif
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, ev(0,0,0,0,0,0,1,3'd2), "proto_idle");
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, ev(0,0,0,0,0,0,1,3'd2), "proto_reset");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,3'd0), "proto_cleared");

        @(posedge clk);
        #1;
        tests_run = tests_run + 1;
        if (exp_q.size() != 0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL scoreboard_drain actual=%0d left required=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
